// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, default frame
// width and the index-width helper used by the interface and the sub-modules.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StWait  = 2'd2,
      StGap   = 2'd3
   } state_e;

   localparam int unsigned DefaultDbits = 8;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART TX arbiter.
// master: the arbiter side; slave: requesters plus transmitter.
interface uart_tx_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned DBITS = uart_tx_arbiter_pkg::DefaultDbits
);
   localparam int unsigned IdxW = uart_tx_arbiter_pkg::idx_width(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ*DBITS-1:0] req_data;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic                  tx_start;
   logic [DBITS-1:0]      tx_din;
   logic                  tx_done_tick;
   logic                  busy;
   logic [IdxW-1:0]       owner_id;

   modport master (
      input  req, req_data, tx_done_tick,
      output grant, done, tx_start, tx_din, busy, owner_id
   );

   modport slave (
      output req, req_data, tx_done_tick,
      input  grant, done, tx_start, tx_din, busy, owner_id
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter_comb.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping explicitly at N-1 so non-power-of-two N works.
module rr_arbiter_comb
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IdxW = idx_width(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [IdxW-1:0] sel_o,
   output logic            valid_o
);

   // One extra bit so ptr + offset cannot overflow before the wrap.
   logic [IdxW:0] idx;

   // Scan N candidates starting at the pointer; keep the first hit.
   always_comb begin
      sel_o   = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = {1'b0, ptr_i} + (IdxW + 1)'(k);
         if (idx >= (IdxW + 1)'(N)) begin
            idx = idx - (IdxW + 1)'(N);
         end
         if (!valid_o && req_i[idx[IdxW-1:0]]) begin
            valid_o = 1'b1;
            sel_o   = idx[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte requesters. Grants round-robin,
// latches the winner's byte, pulses tx_start, waits for tx_done_tick, reports
// done and then holds off for an inter-frame gap. All outputs are registered.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned DBITS      = DefaultDbits,
   parameter int unsigned GAP_CYCLES = 1
) (
   input logic               clk,
   input logic               reset_n,
   uart_tx_arbiter_if.master bus_io
);

   localparam int unsigned IdxW = idx_width(NREQ);

   state_e           state_q, state_d;
   logic [IdxW-1:0]  ptr_q, ptr_d;
   logic [IdxW-1:0]  owner_q, owner_d;
   logic [7:0]       gap_q, gap_d;
   logic [DBITS-1:0] data_q, data_d;
   logic [DBITS-1:0] tx_din_q, tx_din_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic             tx_start_q, tx_start_d;

   logic [IdxW-1:0]  sel;
   logic             sel_valid;

   rr_arbiter_comb #(
      .N (NREQ)
   ) u_rr (
      .req_i   (bus_io.req),
      .ptr_i   (ptr_q),
      .sel_o   (sel),
      .valid_o (sel_valid)
   );

   // Next-state and registered-output decode.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      gap_d      = gap_q;
      data_d     = data_q;
      tx_din_d   = tx_din_q;
      grant_d    = '0;
      done_d     = '0;
      tx_start_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (sel_valid) begin
               data_d         = bus_io.req_data[int'(sel) * DBITS +: DBITS];
               owner_d        = sel;
               grant_d[sel]   = 1'b1;
               state_d        = StStart;
            end
         end
         StStart: begin
            tx_start_d = 1'b1;
            tx_din_d   = data_q;
            state_d    = StWait;
         end
         StWait: begin
            if (bus_io.tx_done_tick) begin
               done_d[owner_q] = 1'b1;
               ptr_d   = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
               gap_d   = 8'(GAP_CYCLES - 1);
               // The IDLE arbitration cycle is the last gap cycle, so a
               // one-cycle gap needs no GAP state at all.
               state_d = (GAP_CYCLES > 1) ? StGap : StIdle;
            end
         end
         StGap: begin
            gap_d = gap_q - 8'd1;
            if (gap_q == 8'd1) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         owner_q    <= '0;
         gap_q      <= '0;
         data_q     <= '0;
         tx_din_q   <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         gap_q      <= gap_d;
         data_q     <= data_d;
         tx_din_q   <= tx_din_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         tx_start_q <= tx_start_d;
      end
   end

   assign bus_io.grant    = grant_q;
   assign bus_io.done     = done_q;
   assign bus_io.tx_start = tx_start_q;
   assign bus_io.tx_din   = tx_din_q;
   assign bus_io.busy     = (state_q != StIdle);
   assign bus_io.owner_id = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (NREQ=4, DBITS=8, GAP_CYCLES=3). A monitor logs
// grant/tx_start/done events with cycle stamps; tasks push expected frames and
// compare against the logged events.
module tb_uart_tx_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned DBITS = 8;
   localparam int unsigned GAP   = 3;
   localparam int unsigned TXLAT = 4;

   typedef struct {
      int         owner;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   logic            clk     = 1'b0;
   logic            reset_n = 1'b0;
   logic [NREQ-1:0] hold    = '0;
   int              checks  = 0;
   int              errors  = 0;
   int              cyc     = 0;
   int              viol    = 0;

   ev_t start_q[$];
   ev_t done_q[$];
   ev_t grant_q[$];
   ev_t exp_q[$];

   uart_tx_arbiter_if #(.NREQ(NREQ), .DBITS(DBITS)) bus ();

   uart_tx_arbiter #(
      .NREQ       (NREQ),
      .DBITS      (DBITS),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus_io  (bus)
   );

   always #5 clk = ~clk;

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Event logger: cycle n is the interval after posedge n.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      #1;
      if (bus.tx_start) start_q.push_back('{int'(bus.owner_id), bus.tx_din, cyc});
      if (|bus.grant) grant_q.push_back('{onehot_idx(bus.grant), 8'h00, cyc});
      if (|bus.done) done_q.push_back('{onehot_idx(bus.done), 8'h00, cyc});
      if ($countones(bus.grant) > 1 || $countones(bus.done) > 1 || (|bus.grant && |bus.done))
         viol <= viol + 1;
   end

   // Granted requesters drop req (unless held) and change their byte.
   task automatic service_reqs();
      for (int i = 0; i < NREQ; i++) begin
         if (bus.grant[i] && !hold[i]) begin
            bus.req[i] = 1'b0;
            bus.req_data[i*DBITS +: DBITS] = 8'($urandom);
         end
      end
   endtask

   // which: 0 = tx_start, 1 = done, 2 = grant. Bounded wait.
   task automatic wait_event(input int which, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         service_reqs();
         if ((which == 0 && start_q.size() > 0) || (which == 1 && done_q.size() > 0) ||
             (which == 2 && grant_q.size() > 0)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Transmitter model: tick TXLAT cycles later; k = cycle the tick is high.
   task automatic finish_frame(output int k);
      repeat (TXLAT) begin
         @(negedge clk);
         service_reqs();
      end
      bus.tx_done_tick = 1'b1;
      k = cyc;
      @(negedge clk);
      service_reqs();
      bus.tx_done_tick = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n          = 1'b0;
      bus.req          = '0;
      bus.req_data     = '0;
      bus.tx_done_tick = 1'b0;
      hold             = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      start_q.delete();
      done_q.delete();
      grant_q.delete();
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0", bus.grant); end
      checks++;
      if (bus.done !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++;
      if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
      checks++;
      if (bus.tx_din !== '0) begin errors++; $display("FAIL reset_tx_din: got %h want 00", bus.tx_din); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++;
      if (bus.owner_id !== '0) begin errors++; $display("FAIL reset_owner: got %0d want 0", bus.owner_id); end
   endtask

   task automatic test_single();
      bit  ok;
      ev_t e, x;
      int  k0, k, gcyc;
      apply_reset();
      bus.req_data = {8'h3C, 8'h77, 8'hA5, 8'h11};
      bus.req      = 4'b0010;
      k0           = cyc;
      exp_q.push_back('{1, 8'hA5, 0});
      wait_event(2, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_grant: got none want grant"); return; end
      e = grant_q.pop_front();
      gcyc = e.cyc;
      checks++;
      if (e.owner !== 1 || e.cyc - k0 !== 1) begin
         errors++; $display("FAIL single_grant: got idx %0d lat %0d want idx 1 lat 1", e.owner, e.cyc - k0);
      end
      wait_event(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_start: got none want tx_start"); return; end
      e = start_q.pop_front();
      x = exp_q.pop_front();
      checks++;
      if (e.owner !== x.owner || e.data !== x.data || e.cyc - gcyc !== 1) begin
         errors++;
         $display("FAIL single_start: got own %0d din %h lat %0d want own %0d din %h lat 1",
                  e.owner, e.data, e.cyc - gcyc, x.owner, x.data);
      end
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
      finish_frame(k);
      wait_event(1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_done: got none want done"); return; end
      e = done_q.pop_front();
      checks++;
      if (e.owner !== 1 || e.cyc - k !== 1) begin
         errors++; $display("FAIL single_done: got idx %0d lat %0d want idx 1 lat 1", e.owner, e.cyc - k);
      end
   endtask

   task automatic test_all_four();
      bit         ok;
      ev_t        e, x;
      int         k;
      logic [7:0] b;
      apply_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NREQ; i++) begin
            b = 8'($urandom);
            bus.req_data[i*DBITS +: DBITS] = b;
            exp_q.push_back('{i, b, 0});
         end
         bus.req = '1;
         for (int f = 0; f < NREQ; f++) begin
            wait_event(0, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL all4_start r%0d f%0d: got none", r, f); return; end
            e = start_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (e.owner !== x.owner || e.data !== x.data) begin
               errors++;
               $display("FAIL all4_start r%0d f%0d: got own %0d din %h want own %0d din %h",
                        r, f, e.owner, e.data, x.owner, x.data);
            end
            finish_frame(k);
            wait_event(1, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL all4_done r%0d f%0d: got none", r, f); return; end
            e = done_q.pop_front();
            checks++;
            if (e.owner !== x.owner) begin
               errors++; $display("FAIL all4_done r%0d f%0d: got %0d want %0d", r, f, e.owner, x.owner);
            end
         end
      end
   endtask

   task automatic test_fairness();
      bit         ok;
      ev_t        e, x;
      int         k;
      logic [7:0] d0, d2;
      apply_reset();
      d0 = 8'($urandom);
      d2 = 8'($urandom);
      bus.req_data[0*DBITS +: DBITS] = d0;
      bus.req_data[2*DBITS +: DBITS] = d2;
      exp_q.push_back('{0, d0, 0});
      exp_q.push_back('{2, d2, 0});
      exp_q.push_back('{0, d0, 0});
      hold    = 4'b0001;
      bus.req = 4'b0101;
      for (int f = 0; f < 3; f++) begin
         wait_event(0, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL fair_start f%0d: got none", f); return; end
         e = start_q.pop_front();
         x = exp_q.pop_front();
         checks++;
         if (e.owner !== x.owner || e.data !== x.data) begin
            errors++;
            $display("FAIL fair_start f%0d: got own %0d din %h want own %0d din %h",
                     f, e.owner, e.data, x.owner, x.data);
         end
         if (f == 2) begin
            hold    = '0;
            bus.req = '0;
         end
         finish_frame(k);
         wait_event(1, ok);
         void'(done_q.pop_front());
      end
   endtask

   task automatic test_gap();
      bit         ok;
      ev_t        e, x;
      int         k;
      logic [7:0] da, db;
      apply_reset();
      da = 8'($urandom);
      db = 8'($urandom);
      bus.req_data[0*DBITS +: DBITS] = da;
      bus.req = 4'b0001;
      exp_q.push_back('{0, da, 0});
      wait_event(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL gap_first_start: got none"); return; end
      void'(start_q.pop_front());
      void'(exp_q.pop_front());
      bus.req_data[1*DBITS +: DBITS] = db;
      bus.req[1] = 1'b1;
      exp_q.push_back('{1, db, 0});
      finish_frame(k);
      wait_event(1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL gap_done: got none"); return; end
      e = done_q.pop_front();
      checks++;
      if (e.owner !== 0 || e.cyc - k !== 1) begin
         errors++; $display("FAIL gap_done: got idx %0d lat %0d want idx 0 lat 1", e.owner, e.cyc - k);
      end
      wait_event(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL gap_second_start: got none"); return; end
      e = start_q.pop_front();
      x = exp_q.pop_front();
      checks++;
      if (e.cyc - k !== int'(GAP) + 2) begin
         errors++; $display("FAIL gap_timing: got %0d cycles want %0d", e.cyc - k, GAP + 2);
      end
      checks++;
      if (e.owner !== x.owner || e.data !== x.data) begin
         errors++;
         $display("FAIL gap_data: got own %0d din %h want own %0d din %h", e.owner, e.data, x.owner, x.data);
      end
      finish_frame(k);
      wait_event(1, ok);
      void'(done_q.pop_front());
   endtask

   task automatic test_spurious();
      bit         ok;
      ev_t        e, x;
      int         k;
      logic [7:0] d3;
      apply_reset();
      bus.tx_done_tick = 1'b1;
      @(negedge clk);
      bus.tx_done_tick = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (done_q.size() !== 0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL spur_idle: got %0d dones busy %b want 0 dones busy 0", done_q.size(), bus.busy);
      end
      d3 = 8'($urandom);
      bus.req_data[3*DBITS +: DBITS] = d3;
      bus.req = 4'b1000;
      exp_q.push_back('{3, d3, 0});
      wait_event(2, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL spur_grant: got none"); return; end
      bus.tx_done_tick = 1'b1;
      @(negedge clk);
      bus.tx_done_tick = 1'b0;
      wait_event(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL spur_start: got none"); return; end
      e = start_q.pop_front();
      x = exp_q.pop_front();
      checks++;
      if (e.owner !== x.owner || e.data !== x.data) begin
         errors++;
         $display("FAIL spur_start: got own %0d din %h want own %0d din %h", e.owner, e.data, x.owner, x.data);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done_q.size() !== 0 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL spur_start_tick: got %0d dones busy %b want 0 dones busy 1", done_q.size(), bus.busy);
      end
      finish_frame(k);
      wait_event(1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL spur_done: got none"); return; end
      e = done_q.pop_front();
      checks++;
      if (e.owner !== 3) begin errors++; $display("FAIL spur_done: got %0d want 3", e.owner); end
      // The bench is now inside the gap; a tick here must be ignored.
      bus.tx_done_tick = 1'b1;
      @(negedge clk);
      bus.tx_done_tick = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (done_q.size() !== 0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL spur_gap: got %0d dones busy %b want 0 dones busy 0", done_q.size(), bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      bit         ok;
      ev_t        e, x;
      int         k;
      logic [7:0] d0, d3;
      apply_reset();
      bus.req_data[2*DBITS +: DBITS] = 8'hC3;
      bus.req = 4'b0100;
      exp_q.push_back('{2, 8'hC3, 0});
      wait_event(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_mid_start: got none"); return; end
      void'(start_q.pop_front());
      void'(exp_q.pop_front());
      repeat (2) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.grant, bus.done, bus.tx_start, bus.tx_din, bus.busy, bus.owner_id} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got grant %b done %b start %b din %h busy %b own %0d want all 0",
                  bus.grant, bus.done, bus.tx_start, bus.tx_din, bus.busy, bus.owner_id);
      end
      @(negedge clk);
      bus.req = '0;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (done_q.size() !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d want 0", done_q.size()); end
      d3 = 8'($urandom);
      bus.req_data[3*DBITS +: DBITS] = d3;
      bus.req = 4'b1000;
      exp_q.push_back('{3, d3, 0});
      wait_event(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_after_start: got none"); return; end
      e = start_q.pop_front();
      x = exp_q.pop_front();
      checks++;
      if (e.owner !== x.owner || e.data !== x.data) begin
         errors++;
         $display("FAIL rst_after_start: got own %0d din %h want own %0d din %h", e.owner, e.data, x.owner, x.data);
      end
      finish_frame(k);
      wait_event(1, ok);
      void'(done_q.pop_front());
      // Owner 3 wraps the pointer to 0.
      d0 = 8'($urandom);
      bus.req_data[0*DBITS +: DBITS] = d0;
      bus.req = '1;
      exp_q.push_back('{0, d0, 0});
      wait_event(0, ok);
      bus.req = '0;
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_start: got none"); return; end
      e = start_q.pop_front();
      x = exp_q.pop_front();
      checks++;
      if (e.owner !== x.owner || e.data !== x.data) begin
         errors++;
         $display("FAIL wrap_start: got own %0d din %h want own %0d din %h", e.owner, e.data, x.owner, x.data);
      end
      finish_frame(k);
      wait_event(1, ok);
      void'(done_q.pop_front());
   endtask

   task automatic test_invariants();
      checks++;
      if (viol !== 0) begin
         errors++; $display("FAIL onehot_invariant: got %0d bad cycles want 0", viol);
      end
   endtask

   initial begin
      bus.req          = '0;
      bus.req_data     = '0;
      bus.tx_done_tick = 1'b0;
      test_reset();
      test_single();
      test_all_four();
      test_fairness();
      test_gap();
      test_spurious();
      test_reset_mid();
      test_invariants();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (tx_start / tx_din / tx_done_tick handshake) between NREQ byte requesters using round-robin arbitration.
- Latches the winning requester's byte and issues a single-cycle tx_start to the transmitter.
- Holds tx_din stable until the transmitter's tx_done_tick, then reports completion to the owner and enforces an inter-frame gap.
- Sits between the application-side byte producers and the transmitter, on the same clk/s_tick domain.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DBITS, 8, data bits per frame; must match the transmitter.
- GAP_CYCLES, 1, minimum clk cycles between tx_done_tick and the next tx_start (1..255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester.
- req_data  in  NREQ*DBITS  byte for requester i at bits [i*DBITS +: DBITS].
- grant  out  NREQ  one-hot, 1-cycle pulse: the byte of requester i is latched.
- done  out  NREQ  one-hot, 1-cycle pulse: the frame of requester i has completed.
- tx_start  out  1  1-cycle start pulse to the transmitter.
- tx_din  out  DBITS  byte to the transmitter; stable from START until done.
- tx_done_tick  in  1  transmitter frame-complete pulse.
- busy  out  1  high in any state other than IDLE.
- owner_id  out  max(1,$clog2(NREQ))  index of the current/last owner.

Behaviour:
- Reset values: grant=0, done=0, tx_start=0, tx_din=0, busy=0, owner_id=0, rr pointer=0, gap counter=0, state=IDLE.
- All outputs are registered. No combinational path from req or tx_done_tick to any output.

State machine:
- IDLE: when any req bit is set, select the first set bit searching upward from the rr pointer, wrapping modulo NREQ.
  - Next cycle: data_reg<=req_data[sel], owner_id<=sel, grant[sel]=1 for one cycle. Go to START.
  - No req set: stay in IDLE.
- START: tx_start=1 for exactly one cycle, tx_din=data_reg. Go to WAIT.
- WAIT: tx_din held. On tx_done_tick=1:
  - done[owner_id]=1 for one cycle next cycle.
  - rr pointer <= (owner_id+1) mod NREQ.
  - Load the gap counter with GAP_CYCLES-1 and go to GAP.
- GAP: decrement the counter; when it is 0, go to IDLE.
  - This guarantees tx_start is never asserted in the cycle tx_done_tick is high, nor the cycle after.

Latency and throughput:
- req rising edge to grant: 1 cycle.
- grant to tx_start: 1 cycle.
- tx_done_tick to done: 1 cycle.
- Back-to-back frames: tx_done_tick to the next tx_start is GAP_CYCLES+2 cycles.

Requester rule:
- req is sampled as a level. A requester must drop req in the cycle after its grant.
- If req is still high at the next arbitration, a new frame is sent with the then-current req_data.
- req dropping before grant means the requester is not served, with no side effects.

Boundary conditions:
- Simultaneous requests: round-robin ordering; a single continuous requester cannot starve the others.
- NREQ not a power of two: the pointer wraps explicitly at NREQ-1 to 0.
- tx_done_tick in IDLE, START or GAP: ignored (no done pulse, no state change).
- req_data changing after grant: has no effect on tx_din.
- reset_n asserted mid-frame: immediate return to the reset values. The transmitter shares reset_n, so the line idles high; the owner gets no done pulse.
- At most one grant bit and at most one done bit are set in any cycle. grant and done never pulse in the same cycle.

Decomposition:
- Shared uart_pkg: state encoding (IDLE, START, WAIT, GAP) and the default DBITS=8.
- One natural sub-module: rr_arbiter_comb, a combinational round-robin priority pick (req, pointer -> sel index, valid). It is reusable for a future RX-side distributor.
- The FSM, data register and gap counter stay in uart_tx_arbiter.

Test Plan:
- Single request: req=4'b0010, req_data[1]=8'hA5 -> grant=4'b0010 after 1 cycle, tx_start one cycle later with tx_din=8'hA5. After an injected tx_done_tick, done=4'b0010 one cycle later.
- All four requesting, each holding req until its grant: grants in order 0,1,2,3. After req=4'b1111 is re-asserted, the order continues 0,1,2,3 (pointer wrapped). Each tx_din matches the owner's byte.
- Fairness: req[0] held high continuously plus req[2] pulsed once -> order 0,2,0.
- Gap timing with GAP_CYCLES=3 and a pending request: tx_start occurs exactly 5 cycles after tx_done_tick. No tx_start in the tx_done_tick cycle.
- Spurious tx_done_tick in IDLE and START -> no done pulse; state unchanged; frame completes normally on the real tick.
- reset_n low during WAIT -> all outputs 0 asynchronously. After release, a request for requester 3 is granted first (pointer=0, only req[3] set) with correct data.
